present_sbox_dec_serial: RTL

PRESENT_SBOX_DEC_SERIAL -- requirements
Module: present_sbox_dec_serial

---
 rtl/present_pkg.sv | 19 +
 rtl/inv_sbox4.sv | 11 +
 rtl/present_sbox_dec_serial.sv | 113 +++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT inverse-S-layer definitions: lookup table, default state size, FSM states.
package present_pkg;

  localparam int unsigned STATE_W = 64;

  // Nibble i of the table holds the inverse S-box entry for input value i.
  localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] inv_sbox_lut(input logic [3:0] x);
    return INV_SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/inv_sbox4.sv
// 4-bit combinational PRESENT inverse S-box.
module inv_sbox4
  import present_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] sub_c
);

  assign sub_c = inv_sbox_lut(nib);

endmodule

// File: rtl/present_sbox_dec_serial.sv
// Serialised PRESENT inverse S-layer with valid/ready handshake on both sides.
// Define SBOX_DEC_QUAD_EN to substitute four nibbles per cycle instead of one.
module present_sbox_dec_serial
  import present_pkg::*;
#(
  parameter int unsigned WIDTH = STATE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = $clog2(NIBBLES);
`ifdef SBOX_DEC_QUAD_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - LANES);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(LANES);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               subst_done_q, subst_done_d;
  logic               out_valid_d;
  logic [4*LANES-1:0] sbox_in, sbox_out;
  logic               accept, handshake;

  // Shared inverse S-box lanes reading the nibbles selected by the counter.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sbox_in[4*k +: 4] = work_q[{cnt_q + CNT_W'(k), 2'b00} +: 4];

    inv_sbox4 u_inv_sbox4 (
      .nib   (sbox_in[4*k +: 4]),
      .sub_c (sbox_out[4*k +: 4])
    );
  end

  // Ready in DONE depends on out_ready so a new word can be taken with no bubble.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign out_data  = work_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      cnt_q        <= '0;
      subst_done_q <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      subst_done_q <= subst_done_d;
      out_valid    <= out_valid_d;
    end
  end

  // Next-state logic; one cycle after the last substitution the result is presented.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    subst_done_d = subst_done_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = BUSY;
          work_d       = in_data;
          cnt_d        = '0;
          subst_done_d = 1'b0;
        end
      end
      BUSY: begin
        if (subst_done_q) begin
          state_d = DONE;
        end else begin
          for (int k = 0; k < LANES; k++) begin
            work_d[{cnt_q + CNT_W'(k), 2'b00} +: 4] = sbox_out[4*k +: 4];
          end
          if (cnt_q == CNT_LAST) subst_done_d = 1'b1;
          else                   cnt_d        = cnt_q + CNT_STEP;
        end
      end
      DONE: begin
        if (handshake) begin
          if (accept) begin
            state_d      = BUSY;
            work_d       = in_data;
            cnt_d        = '0;
            subst_done_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
  end

endmodule
